// File: rtl/nx_indirect_access_arb.sv
// Round-robin arbiter sharing one indirect-access array port between N_REQ controllers.
// Ownership moves only on a yield or a dropped req, so a command in progress is never cut off.
module nx_indirect_access_arb #(
   parameter int N_REQ       = 2,
   parameter int N_ADDR_BITS = 5,
   parameter int N_DATA_BITS = 64,
   parameter int MAX_HOLD    = 16,
   localparam int IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_REQ-1:0]               req,
   input  logic [N_REQ-1:0]               yield,
   input  logic [N_REQ-1:0]               cs,
   input  logic [N_REQ-1:0]               we,
   input  logic [N_REQ*N_ADDR_BITS-1:0]   add,
   input  logic [N_REQ*N_DATA_BITS-1:0]   wdat,
   output logic [N_REQ-1:0]               grant,
   output logic [N_REQ-1:0]               yield_req,
   output logic [N_REQ-1:0]               rd_vld,
   output logic [N_DATA_BITS-1:0]         rd_dat,
   output logic [IW-1:0]                  owner_id,
   output logic                           err_cs_nogrant,
   output logic                           mem_cs,
   output logic                           mem_we,
   output logic [N_ADDR_BITS-1:0]         mem_add,
   output logic [N_DATA_BITS-1:0]         mem_wdat,
   input  logic [N_DATA_BITS-1:0]         mem_rdat
);

   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OWNED = 1'b1;

   logic [0:0]       state;
   logic [IW-1:0]    last_owner;
   logic [HW-1:0]    hold_cnt;
   logic [HW-1:0]    hold_next;
   logic             hold_hit;
   logic             release_now;
   logic [N_REQ-1:0] others;
   logic [IW:0]      idle_pick;
   logic [IW:0]      rel_pick;

   // Returns {found, index}: first set bit scanning after+1 .. after, wrapping.
   function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] mask,
                                           input logic [IW-1:0] after);
      logic [IW:0]   res;
      logic [IW-1:0] cand;
      int            idx;
      res = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = int'(after) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = IW'(idx);
         if (mask[cand]) res = {1'b1, cand};
      end
      return res;
   endfunction

   function automatic logic [N_REQ-1:0] to_onehot(input logic [IW-1:0] idx);
      logic [N_REQ-1:0] v;
      v = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IW'(i) == idx) v[i] = 1'b1;
      end
      return v;
   endfunction

   assign others      = req & ~grant;
   assign release_now = (state == ST_OWNED) && (yield[owner_id] || !req[owner_id]);
   assign idle_pick   = rr_pick(req, last_owner);
   // The releasing owner is masked out, so it can only win again via IDLE.
   assign rel_pick    = rr_pick(others, owner_id);
   assign hold_next   = ((MAX_HOLD == 0) || (hold_cnt == HOLD_MAX)) ? hold_cnt : hold_cnt + 1'b1;
   assign hold_hit    = (MAX_HOLD != 0) && (hold_next >= HOLD_MAX);
   assign rd_dat      = mem_rdat;

   always_comb begin
      mem_cs   = 1'b0;
      mem_we   = 1'b0;
      mem_add  = '0;
      mem_wdat = '0;
      if (state == ST_OWNED) begin
         mem_cs   = cs[owner_id];
         mem_we   = we[owner_id];
         mem_add  = add[int'(owner_id)*N_ADDR_BITS +: N_ADDR_BITS];
         mem_wdat = wdat[int'(owner_id)*N_DATA_BITS +: N_DATA_BITS];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         grant          <= '0;
         yield_req      <= '0;
         rd_vld         <= '0;
         owner_id       <= '0;
         last_owner     <= IW'(N_REQ - 1);
         hold_cnt       <= '0;
         err_cs_nogrant <= 1'b0;
      end else begin
         err_cs_nogrant <= |(cs & ~grant);
         // grant still names the issuer here, even if ownership moves on this edge.
         rd_vld         <= (mem_cs && !mem_we) ? grant : '0;
         case (state)
            ST_IDLE: begin
               if (idle_pick[IW]) begin
                  state      <= ST_OWNED;
                  grant      <= to_onehot(idle_pick[IW-1:0]);
                  owner_id   <= idle_pick[IW-1:0];
                  last_owner <= idle_pick[IW-1:0];
                  hold_cnt   <= '0;
                  yield_req  <= '0;
               end
            end
            default: begin
               if (release_now) begin
                  hold_cnt  <= '0;
                  yield_req <= '0;
                  if (rel_pick[IW]) begin
                     grant      <= to_onehot(rel_pick[IW-1:0]);
                     owner_id   <= rel_pick[IW-1:0];
                     last_owner <= rel_pick[IW-1:0];
                  end else begin
                     state <= ST_IDLE;
                     grant <= '0;
                  end
               end else begin
                  hold_cnt  <= hold_next;
                  yield_req <= (hold_hit && (|others)) ? grant : '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nx_indirect_access_arb.sv
// Directed bench for nx_indirect_access_arb: grant/handoff, read return, hold limit,
// non-owner strobes and mid-operation reset, with a queue-based read-return scoreboard.
module tb_nx_indirect_access_arb;

   localparam int N_REQ = 2;
   localparam int AW    = 5;
   localparam int DW    = 64;
   localparam int IW    = 1;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [N_REQ-1:0]      req, yield, cs, we;
   logic [N_REQ*AW-1:0]   add;
   logic [N_REQ*DW-1:0]   wdat;
   logic [N_REQ-1:0]      grant, yield_req, rd_vld;
   logic [DW-1:0]         rd_dat;
   logic [IW-1:0]         owner_id;
   logic                  err_cs_nogrant, mem_cs, mem_we;
   logic [AW-1:0]         mem_add;
   logic [DW-1:0]         mem_wdat;
   logic [DW-1:0]         mem_rdat = '0;

   logic [DW-1:0]         mem_arr [32];
   logic [N_REQ+DW-1:0]   exp_q [$];
   int                    n_tests = 0;
   int                    n_fail  = 0;

   nx_indirect_access_arb #(
      .N_REQ(N_REQ), .N_ADDR_BITS(AW), .N_DATA_BITS(DW), .MAX_HOLD(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .yield(yield), .cs(cs), .we(we),
      .add(add), .wdat(wdat), .grant(grant), .yield_req(yield_req), .rd_vld(rd_vld),
      .rd_dat(rd_dat), .owner_id(owner_id), .err_cs_nogrant(err_cs_nogrant),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_add(mem_add), .mem_wdat(mem_wdat),
      .mem_rdat(mem_rdat)
   );

   // clock / array model
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we) mem_arr[mem_add] <= mem_wdat;
         else        mem_rdat <= mem_arr[mem_add];
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue_read(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cs[id] = 1'b1;
      we[id] = 1'b0;
      add[id*AW +: AW] = a;
      exp_q.push_back({N_REQ'(1) << id, d});
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [N_REQ+DW-1:0] e;
      if (rst_n === 1'b1 && rd_vld !== '0) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: got rd_vld=%b rd_dat=%0h expected none", rd_vld, rd_dat);
         end else begin
            e = exp_q.pop_front();
            if ({rd_vld, rd_dat} !== e) begin
               n_fail++;
               $display("FAIL rd_return: got vld=%b dat=%0h expected vld=%b dat=%0h",
                        rd_vld, rd_dat, e[N_REQ+DW-1:DW], e[DW-1:0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      req = '0; yield = '0; cs = '0; we = '0; add = '0; wdat = '0;
      for (int i = 0; i < 32; i++) mem_arr[i] = 64'h0;
      mem_arr[5] = 64'hA5;

      // reset state
      tick(); tick();
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_yield_req", 64'(yield_req), 64'h0);
      chk("rst_rd_vld", 64'(rd_vld), 64'h0);
      chk("rst_err", 64'(err_cs_nogrant), 64'h0);
      chk("rst_owner", 64'(owner_id), 64'h0);
      chk("rst_mem_cs", 64'(mem_cs), 64'h0);
      rst_n = 1'b1;
      tick();

      // T1: first grant to 0, handoffs with no gap
      req = 2'b11;
      tick();
      chk("t1_grant0", 64'(grant), 64'h1);
      chk("t1_owner0", 64'(owner_id), 64'h0);
      yield = 2'b01;
      tick();
      chk("t1_grant1", 64'(grant), 64'h2);
      chk("t1_owner1", 64'(owner_id), 64'h1);
      yield = 2'b10;
      tick();
      chk("t1_grant0_again", 64'(grant), 64'h1);
      yield = 2'b00;

      // T2: read at 5, write then read back at 9
      req = 2'b01;
      issue_read(0, 5'd5, 64'hA5);
      settle();
      chk("t2_mem_cs", 64'(mem_cs), 64'h1);
      chk("t2_mem_we", 64'(mem_we), 64'h0);
      chk("t2_mem_add", 64'(mem_add), 64'h5);
      tick();
      cs = 2'b01; we = 2'b01; add[AW-1:0] = 5'd9; wdat[DW-1:0] = 64'h1234_5678;
      settle();
      chk("t2_mem_wdat", mem_wdat, 64'h1234_5678);
      tick();
      issue_read(0, 5'd9, 64'h1234_5678);
      tick();
      cs = '0; we = '0;
      tick();

      // T3: read and yield together; data still returns to requester 0
      req = 2'b11;
      yield = 2'b01;
      issue_read(0, 5'd5, 64'hA5);
      tick();
      cs = '0; yield = '0;
      chk("t3_grant1", 64'(grant), 64'h2);
      chk("t3_rd_vld0", 64'(rd_vld), 64'h1);
      req = 2'b01;
      tick();
      chk("t3_back_to0", 64'(grant), 64'h1);

      // T4: hold limit of 4 with a waiter, none without
      req = 2'b00;
      tick();
      chk("t4_idle", 64'(grant), 64'h0);
      req = 2'b01;
      tick();
      chk("t4_grant0", 64'(grant), 64'h1);
      req = 2'b11;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("t4_no_yreq_%0d", i), 64'(yield_req), 64'h0);
      end
      tick();
      chk("t4_yreq", 64'(yield_req), 64'h1);
      chk("t4_still_owner0", 64'(grant), 64'h1);
      yield = 2'b01;
      tick();
      yield = '0;
      chk("t4_handoff", 64'(grant), 64'h2);
      chk("t4_yreq_clear", 64'(yield_req), 64'h0);
      req = 2'b01;
      tick();
      chk("t4_grant0_solo", 64'(grant), 64'h1);
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("t4_solo_yreq_%0d", i), 64'(yield_req), 64'h0);
      end

      // T5: strobes from the non-owner are dropped and flagged
      cs = 2'b10; add[2*AW-1:AW] = 5'd7;
      settle();
      chk("t5_mem_cs_off", 64'(mem_cs), 64'h0);
      tick();
      cs = '0;
      chk("t5_err", 64'(err_cs_nogrant), 64'h1);
      tick();
      chk("t5_err_pulse", 64'(err_cs_nogrant), 64'h0);
      cs[1] = 1'b1;
      issue_read(0, 5'd5, 64'hA5);
      settle();
      chk("t5_mem_add_owner", 64'(mem_add), 64'h5);
      tick();
      cs = '0;
      chk("t5_err_both", 64'(err_cs_nogrant), 64'h1);
      tick();

      // T6: reset during a read cycle drops the read
      cs = 2'b01; we = '0; add[AW-1:0] = 5'd5;
      settle();
      rst_n = 1'b0;
      #1;
      chk("t6_grant_async", 64'(grant), 64'h0);
      tick();
      cs = '0;
      chk("t6_rd_vld", 64'(rd_vld), 64'h0);
      req = 2'b11;
      rst_n = 1'b1;
      tick();
      chk("t6_first_winner", 64'(grant), 64'h1);
      req = '0;
      tick(); tick();
      chk("end_queue_empty", 64'(exp_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
